rx_ltssm_sequencer: RTL and testbench
=====================================

Name: rx_ltssm_sequencer

Overview:
- Top-level controller for the RX LTSSM substate checker (ordered-set comparator FSM).
- Issues substate requests, waits for each request's finish/exitTo result and advances to the next substate.
- Counts training retries, applies a per-request watchdog and handles forced re-detect.
- Also owns the shared substate timer: it answers the checker's enableTimer/resetTimer/setTimer with timeOut.

Parameters:
- TICKS_PER_UNIT, 16, clk cycles per timer unit; legal range 1..65535.
- MAX_RETRIES, 3, number of failed training passes before giving up; legal range 1..15.
- WATCHDOG_CYCLES, 4096, maximum clk cycles spent in WAIT without an accepted finish.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  level; training is enabled while high
- forceDetect  in  1  one-cycle pulse; restart training from detectQuiet
- finish  in  1  checker result valid (level; may stay high)
- exitTo  in  4  checker's next-substate code
- setTimer  in  6  timer limit in units
- enableTimer  in  1  timer count enable
- resetTimer  in  1  timer clear, active-low (0 = clear)
- substate  out  4  request code to checker
- timeOut  out  1  timer expired
- linkUp  out  1  training reached L0
- trainingFail  out  1  retries exhausted
- retryCount  out  4  failed passes in the current training attempt
- busy  out  1  high in every state except IDLE and LINKUP

Behaviour:
- Substate codes: 0 detectQuiet … 9 configurationIdle; 10 = L0 (success exit); 4'hF = PARK, which is never a valid request.
- Reset values: substate=4'hF, timeOut=0, linkUp=0, trainingFail=0, retryCount=0, busy=0, FSM=IDLE, target=0, all counters 0.
- FSM states: IDLE, PARK, ISSUE, WAIT, LINKUP, FAILED.
- IDLE: substate=PARK. When start=1, set target=0, clear retryCount, go to PARK next cycle.
- PARK: drive substate=4'hF for exactly one cycle, then go to ISSUE. This guarantees that the checker sees a substate change even when the same code is re-requested.
- ISSUE: drive substate=target, clear the watchdog, go to WAIT. substate holds target throughout WAIT.
- WAIT, finish acceptance: finish is accepted only when finish=1 and the watchdog count is ≥2. This prevents a stale finish from the previous request being accepted.
- WAIT, on accepted finish:
  - exitTo==10: go to LINKUP.
  - exitTo==0 and target!=0: retryCount+1.
    - If the new value equals MAX_RETRIES, go to FAILED.
    - Otherwise target=0 and go to PARK.
  - exitTo==0 and target==0: target=0, go to PARK; not counted as a retry.
  - Any other exitTo: target=exitTo, go to PARK.
- WAIT, watchdog: when the watchdog reaches WATCHDOG_CYCLES-1 without an accepted finish, treat it exactly as exitTo==0.
- LINKUP: linkUp=1, substate holds 10. Leave only on start=0 (go to IDLE) or forceDetect.
- FAILED: trainingFail=1, substate=PARK. Leave only on start=0, which goes to IDLE and clears trainingFail.
- forceDetect=1 in any state except IDLE:
  - Next cycle: target=0, retryCount=0, linkUp=0, trainingFail=0, state=PARK.
  - Priority: forceDetect beats finish and the watchdog in the same cycle.
- start=0 in any state: go to IDLE next cycle, and linkUp and trainingFail clear. start=0 beats forceDetect.
- Timer:
  - A prescaler counts 0..TICKS_PER_UNIT-1 while enableTimer=1; on wrap it increments a 6-bit unit count, which saturates at 63.
  - resetTimer=0 synchronously clears the prescaler, the unit count and timeOut; this beats enable.
  - timeOut is registered: it sets in the cycle after the unit count ≥ setTimer while enableTimer=1, and stays set until resetTimer=0.
  - setTimer=0 → timeOut=1 in the second enabled cycle.
- Asynchronous reset mid-operation returns every output to its reset value immediately.

Optional Feature:
- Macro: SEQ_TRANSITION_COUNT_EN.
- When defined: adds output transitionCount (8 bits, reset 0). It increments on every accepted finish and every watchdog expiry, saturates at 255, and clears on start rising out of IDLE.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Happy path: start=1, and the checker model answers each request 3 cycles after the issue with exitTo=target+1 → substate sequence F,0,F,1,F,2,…,F,9, then linkUp=1 and substate=10, with retryCount=0.
- Retry/fail (MAX_RETRIES=3): model returns exitTo=0 at target=2, three passes → retryCount steps 1,2,3, then trainingFail=1 and substate=F. Drive start=0 → IDLE with trainingFail=0.
- Stale finish: finish held at 1 continuously → each request is accepted no earlier than the 2nd WAIT cycle, and a PARK cycle always precedes it.
- Watchdog (WATCHDOG_CYCLES=16): no finish at target=3 → after 16 WAIT cycles retryCount=1, then PARK, then substate=0.
- forceDetect in the same cycle as finish with exitTo=5 at target=4 → next state PARK, target=0, retryCount=0; exitTo is ignored.
- Timer (TICKS_PER_UNIT=4, setTimer=2): hold enable=1 and resetTimer=1 → timeOut rises on cycle 9. Drive resetTimer=0 → timeOut=0 the next cycle.

Source files
------------

// File: rtl/rx_ltssm_sequencer.sv
// RX LTSSM substate sequencer: issues substate requests to the ordered-set checker,
// tracks retries/watchdog/forced re-detect, and owns the shared substate timer.
// Optional macro SEQ_TRANSITION_COUNT_EN adds the transitionCount output.
module rx_ltssm_sequencer #(
    parameter int TICKS_PER_UNIT  = 16,
    parameter int MAX_RETRIES     = 3,
    parameter int WATCHDOG_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       forceDetect,
    input  logic       finish,
    input  logic [3:0] exitTo,
    input  logic [5:0] setTimer,
    input  logic       enableTimer,
    input  logic       resetTimer,
    output logic [3:0] substate,
    output logic       timeOut,
    output logic       linkUp,
    output logic       trainingFail,
    output logic [3:0] retryCount,
    output logic       busy
`ifdef SEQ_TRANSITION_COUNT_EN
    ,
    output logic [7:0] transitionCount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PARK   = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_LINKUP = 3'd4,
        S_FAILED = 3'd5
    } state_t;

    localparam logic [3:0] LP_PARK = 4'hF;
    localparam logic [3:0] LP_L0   = 4'd10;
    localparam logic [3:0] LP_MAXR = 4'(MAX_RETRIES);

    localparam int WDW_RAW = $clog2(WATCHDOG_CYCLES + 1);
    localparam int WDW     = (WDW_RAW < 2) ? 2 : WDW_RAW;
    localparam logic [WDW-1:0] LP_WD_MAX = WDW'(WATCHDOG_CYCLES - 1);
    localparam logic [WDW-1:0] LP_WD_MIN = WDW'(2);

    localparam logic [15:0] LP_TICK_MAX = 16'(TICKS_PER_UNIT - 1);

    state_t         r_state;
    logic [3:0]     r_target;
    logic [3:0]     r_retry;
    logic [WDW-1:0] r_wd;
    logic [3:0]     r_substate;
    logic           r_link_up;
    logic           r_training_fail;
    logic           r_busy;

    logic [15:0]    r_presc;
    logic [5:0]     r_units;
    logic           r_timeout;

    logic           w_in_wait;
    logic           w_accept;
    logic           w_expire;
    logic           w_to_zero;
    logic [3:0]     w_retry_inc;

    // Decode finish acceptance and watchdog expiry for the current WAIT cycle
    always_comb begin
        w_in_wait   = (r_state == S_WAIT);
        w_accept    = w_in_wait && finish && (r_wd >= LP_WD_MIN);
        w_expire    = w_in_wait && !w_accept && (r_wd == LP_WD_MAX);
        w_to_zero   = w_expire || (w_accept && (exitTo == 4'd0));
        w_retry_inc = r_retry + 4'd1;
    end

    // Sequencer FSM; outputs are registered alongside the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_target        <= 4'd0;
            r_retry         <= 4'd0;
            r_wd            <= '0;
            r_substate      <= LP_PARK;
            r_link_up       <= 1'b0;
            r_training_fail <= 1'b0;
            r_busy          <= 1'b0;
        end else if (!start) begin
            r_state         <= S_IDLE;
            r_substate      <= LP_PARK;
            r_link_up       <= 1'b0;
            r_training_fail <= 1'b0;
            r_busy          <= 1'b0;
        end else if (forceDetect && (r_state != S_IDLE)) begin
            r_state         <= S_PARK;
            r_target        <= 4'd0;
            r_retry         <= 4'd0;
            r_substate      <= LP_PARK;
            r_link_up       <= 1'b0;
            r_training_fail <= 1'b0;
            r_busy          <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_target   <= 4'd0;
                    r_retry    <= 4'd0;
                    r_substate <= LP_PARK;
                    r_busy     <= 1'b1;
                    r_state    <= S_PARK;
                end
                S_PARK: begin
                    r_substate <= r_target;
                    r_state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wd != LP_WD_MAX) begin
                        r_wd <= r_wd + WDW'(1);
                    end else begin
                        r_wd <= r_wd;
                    end
                    if (w_accept && (exitTo == LP_L0)) begin
                        r_substate <= LP_L0;
                        r_link_up  <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_LINKUP;
                    end else if (w_to_zero && (r_target != 4'd0)) begin
                        r_retry    <= w_retry_inc;
                        r_substate <= LP_PARK;
                        if (w_retry_inc == LP_MAXR) begin
                            r_training_fail <= 1'b1;
                            r_state         <= S_FAILED;
                        end else begin
                            r_target <= 4'd0;
                            r_state  <= S_PARK;
                        end
                    end else if (w_to_zero) begin
                        r_target   <= 4'd0;
                        r_substate <= LP_PARK;
                        r_state    <= S_PARK;
                    end else if (w_accept) begin
                        r_target   <= exitTo;
                        r_substate <= LP_PARK;
                        r_state    <= S_PARK;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_LINKUP: begin
                    r_state <= S_LINKUP;
                end
                S_FAILED: begin
                    r_state <= S_FAILED;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_substate <= LP_PARK;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Substate timer: prescaler feeds a saturating unit count; timeOut is sticky until cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc   <= 16'd0;
            r_units   <= 6'd0;
            r_timeout <= 1'b0;
        end else if (!resetTimer) begin
            r_presc   <= 16'd0;
            r_units   <= 6'd0;
            r_timeout <= 1'b0;
        end else if (enableTimer) begin
            if (r_presc >= LP_TICK_MAX) begin
                r_presc <= 16'd0;
                if (r_units != 6'd63) begin
                    r_units <= r_units + 6'd1;
                end else begin
                    r_units <= r_units;
                end
            end else begin
                r_presc <= r_presc + 16'd1;
            end
            if (r_units >= setTimer) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end
        end else begin
            r_presc   <= r_presc;
            r_units   <= r_units;
            r_timeout <= r_timeout;
        end
    end

`ifdef SEQ_TRANSITION_COUNT_EN
    logic [7:0] r_trans_cnt;

    // Count resolved requests (accepted finish or watchdog expiry), cleared when training starts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trans_cnt <= 8'd0;
        end else if (start && (r_state == S_IDLE)) begin
            r_trans_cnt <= 8'd0;
        end else if (start && !forceDetect && (w_accept || w_expire) && (r_trans_cnt != 8'd255)) begin
            r_trans_cnt <= r_trans_cnt + 8'd1;
        end else begin
            r_trans_cnt <= r_trans_cnt;
        end
    end

    assign transitionCount = r_trans_cnt;
`endif

    assign substate     = r_substate;
    assign timeOut      = r_timeout;
    assign linkUp       = r_link_up;
    assign trainingFail = r_training_fail;
    assign retryCount   = r_retry;
    assign busy         = r_busy;

endmodule

// File: tb/tb_rx_ltssm_sequencer.sv
// Directed self-checking bench for rx_ltssm_sequencer (default build, macro undefined).
module tb_rx_ltssm_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       forceDetect;
    logic       finish;
    logic [3:0] exitTo;
    logic [5:0] setTimer;
    logic       enableTimer;
    logic       resetTimer;
    logic [3:0] substate;
    logic       timeOut;
    logic       linkUp;
    logic       trainingFail;
    logic [3:0] retryCount;
    logic       busy;

    int tests = 0;
    int fails = 0;

    rx_ltssm_sequencer #(
        .TICKS_PER_UNIT (4),
        .MAX_RETRIES    (3),
        .WATCHDOG_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .forceDetect (forceDetect),
        .finish      (finish),
        .exitTo      (exitTo),
        .setTimer    (setTimer),
        .enableTimer (enableTimer),
        .resetTimer  (resetTimer),
        .substate    (substate),
        .timeOut     (timeOut),
        .linkUp      (linkUp),
        .trainingFail(trainingFail),
        .retryCount  (retryCount),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From PARK: issue tgt, then answer with ex on the third WAIT cycle
    task automatic run_req(input logic [3:0] tgt, input logic [3:0] ex);
        tick();
        check("issue_substate", {28'd0, substate}, {28'd0, tgt});
        tick();
        tick();
        tick();
        finish = 1'b1;
        exitTo = ex;
        tick();
        finish = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        forceDetect = 1'b0;
        finish      = 1'b0;
        exitTo      = 4'd0;
        setTimer    = 6'd0;
        enableTimer = 1'b0;
        resetTimer  = 1'b0;
        #12;
        check("rst_substate", {28'd0, substate}, 32'hF);
        check("rst_timeout", {31'd0, timeOut}, 32'd0);
        check("rst_linkup", {31'd0, linkUp}, 32'd0);
        check("rst_fail", {31'd0, trainingFail}, 32'd0);
        check("rst_retry", {28'd0, retryCount}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();

        // Happy path: each target answered with target+1
        start = 1'b1;
        tick();
        check("happy_park0", {28'd0, substate}, 32'hF);
        check("happy_busy", {31'd0, busy}, 32'd1);
        for (int t = 0; t < 10; t++) begin
            run_req(4'(t), 4'(t + 1));
            if (t < 9) begin
                check("happy_park", {28'd0, substate}, 32'hF);
            end
        end
        check("happy_l0", {28'd0, substate}, 32'd10);
        check("happy_linkup", {31'd0, linkUp}, 32'd1);
        check("happy_busy_l0", {31'd0, busy}, 32'd0);
        check("happy_retry", {28'd0, retryCount}, 32'd0);
        tick();
        check("happy_hold", {28'd0, substate}, 32'd10);

        // Leave LINKUP via start=0
        start = 1'b0;
        tick();
        check("idle_linkup", {31'd0, linkUp}, 32'd0);
        check("idle_substate", {28'd0, substate}, 32'hF);

        // Retry/fail: target 2 always answers detectQuiet
        start = 1'b1;
        tick();
        check("retry_start", {28'd0, retryCount}, 32'd0);
        for (int p = 1; p <= 3; p++) begin
            run_req(4'd0, 4'd1);
            run_req(4'd1, 4'd2);
            run_req(4'd2, 4'd0);
            check("retry_count", {28'd0, retryCount}, 32'(p));
            check("retry_substate", {28'd0, substate}, 32'hF);
            check("retry_fail_flag", {31'd0, trainingFail}, (p == 3) ? 32'd1 : 32'd0);
        end
        check("failed_busy", {31'd0, busy}, 32'd1);
        tick();
        check("failed_hold", {31'd0, trainingFail}, 32'd1);
        start = 1'b0;
        tick();
        check("failed_exit", {31'd0, trainingFail}, 32'd0);
        check("failed_idle_busy", {31'd0, busy}, 32'd0);

        // Stale finish held high: acceptance only on the third WAIT cycle
        start  = 1'b1;
        finish = 1'b1;
        exitTo = 4'd1;
        tick();
        check("stale_park", {28'd0, substate}, 32'hF);
        for (int t = 0; t < 2; t++) begin
            exitTo = 4'(t + 1);
            tick();
            check("stale_issue", {28'd0, substate}, 32'(t));
            for (int w = 0; w < 3; w++) begin
                tick();
                check("stale_wait", {28'd0, substate}, 32'(t));
            end
            tick();
            check("stale_accept_park", {28'd0, substate}, 32'hF);
        end
        finish = 1'b0;
        run_req(4'd2, 4'd3);

        // Watchdog at target 3
        tick();
        check("wd_issue", {28'd0, substate}, 32'd3);
        tick();
        repeat (15) tick();
        check("wd_before", {28'd0, retryCount}, 32'd0);
        check("wd_before_sub", {28'd0, substate}, 32'd3);
        tick();
        check("wd_retry", {28'd0, retryCount}, 32'd1);
        check("wd_park", {28'd0, substate}, 32'hF);
        tick();
        check("wd_reissue", {28'd0, substate}, 32'd0);

        // forceDetect beats finish at target 4
        tick();
        tick();
        tick();
        finish = 1'b1;
        exitTo = 4'd1;
        tick();
        finish = 1'b0;
        run_req(4'd1, 4'd2);
        run_req(4'd2, 4'd3);
        run_req(4'd3, 4'd4);
        tick();
        check("fd_issue", {28'd0, substate}, 32'd4);
        tick();
        tick();
        tick();
        finish      = 1'b1;
        exitTo      = 4'd5;
        forceDetect = 1'b1;
        tick();
        forceDetect = 1'b0;
        finish      = 1'b0;
        check("fd_park", {28'd0, substate}, 32'hF);
        check("fd_retry", {28'd0, retryCount}, 32'd0);
        tick();
        check("fd_target0", {28'd0, substate}, 32'd0);

        // start=0 beats forceDetect
        start       = 1'b0;
        forceDetect = 1'b1;
        tick();
        forceDetect = 1'b0;
        check("stop_busy", {31'd0, busy}, 32'd0);
        check("stop_substate", {28'd0, substate}, 32'hF);

        // Timer: 4 ticks/unit, limit 2 units
        setTimer    = 6'd2;
        enableTimer = 1'b1;
        resetTimer  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("timer_low", {31'd0, timeOut}, 32'd0);
        end
        tick();
        check("timer_rise", {31'd0, timeOut}, 32'd1);
        tick();
        check("timer_sticky", {31'd0, timeOut}, 32'd1);
        resetTimer = 1'b0;
        tick();
        check("timer_clear", {31'd0, timeOut}, 32'd0);
        setTimer   = 6'd0;
        resetTimer = 1'b1;
        check("timer0_first", {31'd0, timeOut}, 32'd0);
        tick();
        check("timer0_second", {31'd0, timeOut}, 32'd1);

        // Asynchronous reset mid-request
        start = 1'b1;
        tick();
        tick();
        check("ar_issue", {28'd0, substate}, 32'd0);
        reset = 1'b0;
        #1;
        check("ar_substate", {28'd0, substate}, 32'hF);
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_timeout", {31'd0, timeOut}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
